// File: rtl/door.sv
// Garage-door motor controller: three-state Moore FSM driving up/down motor enables (optional DOOR_REVERSE_EN).
// Latency: one CLK edge from Activate/limit/RST sample to motor outputs; outputs decoded from registered state.
// Backpressure: none; inputs are sampled every cycle and motor enables are glitch-free registered decodes.
module door (
  input  logic CLK,
  input  logic RST,
  input  logic Activate,
  input  logic UP_Max,
  input  logic DN_Max,
  output logic UP_M,
  output logic DN_M
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MV_UP = 2'b01,
    MV_DN = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;

`ifdef DOOR_REVERSE_EN
  logic act_q;
  logic act_rise;

  // Remember last-cycle Activate so a fresh press can be told apart from a held button
  always_ff @(posedge CLK) begin
    if (!RST) begin
      act_q <= 1'b0;
    end else begin
      act_q <= Activate;
    end
  end

  assign act_rise = Activate & ~act_q;
`endif

  // State register with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; limit switches always win over the button while moving
  always_comb begin
    state_d = state_q;
    case (state_q)
      MV_UP: begin
        if (UP_Max) begin
          state_d = IDLE;
        end
`ifdef DOOR_REVERSE_EN
        else if (act_rise) begin
          state_d = MV_DN;
        end
`endif
      end
      MV_DN: begin
        if (DN_Max) begin
          state_d = IDLE;
        end
`ifdef DOOR_REVERSE_EN
        else if (act_rise) begin
          state_d = MV_UP;
        end
`endif
      end
      default: begin
        // IDLE and the unused code: a part-open or closed door opens, a fully
        // open door closes, and both limits active at once is a sensor fault.
        state_d = IDLE;
        if (Activate) begin
          if (!UP_Max) begin
            state_d = MV_UP;
          end else if (!DN_Max) begin
            state_d = MV_DN;
          end
        end
      end
    endcase
  end

  // Motor enables decoded purely from registered state, so they cannot glitch
  always_comb begin
    UP_M = 1'b0;
    DN_M = 1'b0;
    case (state_q)
      MV_UP:   UP_M = 1'b1;
      MV_DN:   DN_M = 1'b1;
      default: begin
        UP_M = 1'b0;
        DN_M = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_door.sv
// Bench for door: directed scenarios followed by random button/limit traffic.
// Expected motor enables come from a direction-based model (+1 up, -1 down, 0 stopped).
// Inputs are driven 1ns after each rising edge; outputs are sampled at that same point.
module tb_door;

  logic CLK;
  logic RST;
  logic Activate;
  logic UP_Max;
  logic DN_Max;
  logic UP_M;
  logic DN_M;

  int errors;
  int checks;

  // Reference: door travel direction and last-cycle button level
  int dir;
  bit prev_act;

`ifdef DOOR_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  door u_door (
    .CLK      (CLK),
    .RST      (RST),
    .Activate (Activate),
    .UP_Max   (UP_Max),
    .DN_Max   (DN_Max),
    .UP_M     (UP_M),
    .DN_M     (DN_M)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural rules: what the door should be doing after one sampled edge
  task automatic model(input logic r, input logic a, input logic u, input logic d);
    bit press;
    press = a && !prev_act;
    if (!r) begin
      dir = 0;
      prev_act = 1'b0;
    end else begin
      if (dir == 0) begin
        if (a && !u)             dir = 1;
        else if (a && u && !d)   dir = -1;
      end else if (dir > 0) begin
        if (u)                   dir = 0;
        else if (REV && press)   dir = -1;
      end else begin
        if (d)                   dir = 0;
        else if (REV && press)   dir = 1;
      end
      prev_act = a;
    end
  endtask

  task automatic step(input logic r, input logic a, input logic u, input logic d,
                      input string tag);
    RST = r; Activate = a; UP_Max = u; DN_Max = d;
    @(posedge CLK);
    model(r, a, u, d);
    #1;
    check({tag, "_up"}, UP_M, dir > 0);
    check({tag, "_dn"}, DN_M, dir < 0);
    check({tag, "_excl"}, UP_M & DN_M, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    dir = 0;
    prev_act = 1'b0;
    RST = 1'b0; Activate = 1'b0; UP_Max = 1'b0; DN_Max = 1'b0;
    #2;

    // Reset wins over a pressed button
    step(0, 1, 0, 0, "reset");
    step(1, 0, 0, 0, "reset_hold");

    // Open from closed: runs until the upper limit, stops one edge later
    step(1, 1, 0, 1, "open_go");
    step(1, 0, 0, 1, "open_leave");
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, "open_run");
    step(1, 0, 1, 0, "open_stop");
    step(1, 0, 1, 0, "open_idle");

    // Close from fully open; upper limit releases while moving
    step(1, 1, 1, 0, "close_go");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, "close_run");
    step(1, 0, 0, 1, "close_stop");

    // Sensor fault: both limits with button held keeps motors off
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1, "fault");

    // Mid-motion reset, then no motion until the next press
    step(1, 1, 1, 0, "mreset_go");
    step(1, 0, 0, 0, "mreset_run");
    step(0, 0, 0, 0, "mreset_rst");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "mreset_after");

    // Fresh press while opening: reverses only with the reversal option
    step(1, 1, 0, 0, "rev_open");
    step(1, 0, 0, 0, "rev_release");
    step(1, 1, 0, 0, "rev_press");
    step(1, 1, 0, 0, "rev_held");
    step(1, 1, 0, 0, "rev_held2");
    step(1, 0, 1, 1, "rev_stop");

    // Button held across a limit arrival: stops, then the idle rule reverses
    step(1, 0, 0, 0, "hold_idle");
    step(1, 1, 1, 0, "hold_go");
    step(1, 1, 0, 1, "hold_limit");
    step(1, 1, 0, 1, "hold_reverse");
    step(0, 0, 0, 0, "hold_rst");

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0),
           "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
